// File: rtl/mdu_scheduler.sv
// Issue controller for the EX-stage multiply/divide unit: start/load/revoke strobes, latency timing
// and stall request. Define MDU_REVOKE_EN to enable undoing a just-issued op on an exception.
module mdu_scheduler #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [2:0]       op_type,
  input  logic             revoke_req,
  output logic             mul_calculate,
  output logic [1:0]       mul_ctrl,
  output logic             mul_load_HI,
  output logic             mul_load_LO,
  output logic             mul_revoke,
  output logic             busy,
  output logic             stall_req,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [CNT_W-1:0] MulLatCnt = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DivLatCnt = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             revoke_eff;
  logic             go;

`ifdef MDU_REVOKE_EN
  logic last_issue_q;
  // Only an op we strobed last cycle is in MEM and can be undone.
  assign revoke_eff = revoke_req & last_issue_q & ~reset;
`else
  logic unused_revoke;
  assign unused_revoke = revoke_req;
  assign revoke_eff    = 1'b0;
`endif

  assign busy      = (state_q == StBusy);
  assign count     = count_q;
  assign stall_req = op_valid & busy;
  assign go        = op_valid & ~busy & ~revoke_eff & ~reset;

  always_comb begin
    mul_calculate = 1'b0;
    mul_ctrl      = 2'b00;
    mul_load_HI   = 1'b0;
    mul_load_LO   = 1'b0;
    mul_revoke    = revoke_eff;
    if (go) begin
      unique case (op_type)
        3'd0, 3'd1, 3'd2, 3'd3: begin
          mul_calculate = 1'b1;
          mul_ctrl      = {op_type[1], ~op_type[0]};
        end
        3'd4:    mul_load_HI = 1'b1;
        3'd5:    mul_load_LO = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      count_q <= '0;
`ifdef MDU_REVOKE_EN
      last_issue_q <= 1'b0;
`endif
    end else begin
`ifdef MDU_REVOKE_EN
      last_issue_q <= mul_calculate | mul_load_HI | mul_load_LO;
`endif
      if (revoke_eff) begin
        state_q <= StIdle;
        count_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (mul_calculate) begin
              state_q <= StBusy;
              count_q <= op_type[1] ? DivLatCnt : MulLatCnt;
            end
          end
          StBusy: begin
            if (count_q == CntOne) begin
              state_q <= StIdle;
              count_q <= '0;
            end else begin
              count_q <= count_q - CntOne;
            end
          end
          default: begin
            state_q <= StIdle;
            count_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_scheduler.sv
// Scoreboard bench for mdu_scheduler: directed scenarios plus random ops against a cycle-count model.
module tb_mdu_scheduler;

  localparam int MulLat = 5;
  localparam int DivLat = 10;
`ifdef MDU_REVOKE_EN
  localparam bit RevEn = 1'b1;
`else
  localparam bit RevEn = 1'b0;
`endif

  typedef struct packed {
    logic       busy;
    logic       stall;
    logic       calc;
    logic [1:0] ctrl;
    logic       lhi;
    logic       llo;
    logic       rev;
    logic [3:0] cnt;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       op_valid;
  logic [2:0] op_type;
  logic       revoke_req;
  logic       mul_calculate;
  logic [1:0] mul_ctrl;
  logic       mul_load_HI;
  logic       mul_load_LO;
  logic       mul_revoke;
  logic       busy;
  logic       stall_req;
  logic [3:0] count;

  mdu_scheduler #(
    .MUL_LAT(MulLat),
    .DIV_LAT(DivLat),
    .CNT_W  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_type      (op_type),
    .revoke_req   (revoke_req),
    .mul_calculate(mul_calculate),
    .mul_ctrl     (mul_ctrl),
    .mul_load_HI  (mul_load_HI),
    .mul_load_LO  (mul_load_LO),
    .mul_revoke   (mul_revoke),
    .busy         (busy),
    .stall_req    (stall_req),
    .count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_no = 0;
  bit   mon_en = 1'b0;

  // Reference model: cycles of latency still outstanding, and whether last cycle issued a strobe.
  int remaining = 0;
  bit last_issue = 1'b0;

  task automatic cyc(input bit rst, input bit v, input logic [2:0] t, input bit rv);
    obs_t e;
    bit   in_flight, rev, go, is_arith;
    @(posedge clk);
    #1;
    reset = rst; op_valid = v; op_type = t; revoke_req = rv;
    in_flight = (remaining > 0);
    rev       = RevEn && rv && last_issue && !rst;
    go        = v && !in_flight && !rev && !rst;
    is_arith  = (t < 3'd4);
    e.busy  = in_flight;
    e.stall = v && in_flight;
    e.calc  = go && is_arith;
    e.ctrl  = (go && is_arith) ? {(t == 3'd2 || t == 3'd3), (t == 3'd0 || t == 3'd2)} : 2'b00;
    e.lhi   = go && (t == 3'd4);
    e.llo   = go && (t == 3'd5);
    e.rev   = rev;
    e.cnt   = 4'(remaining);
    exp_q.push_back(e);
    mon_en = 1'b1;
    if (rst || rev) remaining = 0;
    else if (e.calc) remaining = (t == 3'd2 || t == 3'd3) ? DivLat : MulLat;
    else if (remaining > 0) remaining = remaining - 1;
    last_issue = !rst && (e.calc || e.lhi || e.llo);
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t got;
    if (mon_en) begin
      cyc_no++;
      got = '{busy: busy, stall: stall_req, calc: mul_calculate, ctrl: mul_ctrl,
              lhi: mul_load_HI, llo: mul_load_LO, rev: mul_revoke, cnt: count};
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_underflow cycle %0d: got %b, no expected entry", cyc_no, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)
          $display("FAIL outputs cycle %0d: got busy/stall/calc/ctrl/hi/lo/rev/cnt=%b required %b",
                   cyc_no, got, e);
        else n_pass++;
      end
    end
  end

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_type = 3'd0; revoke_req = 1'b0;
    repeat (2) @(posedge clk);
    cyc(1, 0, 3'd0, 0);
    // MULT then drain.
    cyc(0, 1, 3'd0, 0);
    repeat (6) cyc(0, 0, 3'd0, 0);
    // DIVU with MFLO waiting behind it.
    cyc(0, 1, 3'd3, 0);
    repeat (11) cyc(0, 1, 3'd7, 0);
    cyc(0, 0, 3'd0, 0);
    // MTHI then MTLO back to back.
    cyc(0, 1, 3'd4, 0);
    cyc(0, 1, 3'd5, 0);
    cyc(0, 0, 3'd0, 0);
    // DIV revoked the next cycle.
    cyc(0, 1, 3'd2, 0);
    cyc(0, 0, 3'd0, 1);
    repeat (11) cyc(0, 0, 3'd0, 0);
    // Late revoke after MULT must be ignored.
    cyc(0, 1, 3'd0, 0);
    cyc(0, 0, 3'd0, 0);
    cyc(0, 0, 3'd0, 0);
    cyc(0, 0, 3'd0, 1);
    repeat (3) cyc(0, 0, 3'd0, 0);
    // Reset while busy.
    cyc(0, 1, 3'd0, 0);
    cyc(0, 0, 3'd0, 0);
    cyc(1, 0, 3'd0, 0);
    cyc(0, 0, 3'd0, 0);
    // MULT with MULTU held behind it.
    cyc(0, 1, 3'd0, 0);
    repeat (6) cyc(0, 1, 3'd1, 0);
    repeat (6) cyc(0, 0, 3'd0, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          r, v, rv;
      logic [2:0]  t;
      r  = ($urandom_range(0, 99) == 0);
      v  = !r && ($urandom_range(0, 3) != 0);
      t  = 3'($urandom_range(0, 7));
      rv = ($urandom_range(0, 3) == 0);
      cyc(r, v, t, rv);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
